// File: rtl/mem_access_unit.sv
// MEM-stage access unit: byte/half/word loads and stores onto a word RAM.
// Sub-word stores are read-modify-write since the RAM has no byte enables.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [3:0]            i_op,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_wdone,
  output logic                  o_fault,
  output logic [ADDR_WIDTH-1:0] o_addra,
  output logic [DATA_WIDTH-1:0] o_dina,
  output logic                  o_wea,
  output logic                  o_ena,
  input  logic [DATA_WIDTH-1:0] i_douta
);

  typedef enum logic [2:0] {
    IDLE, LD, ST, RMW_RD, RMW_WR
  } state_t;

  state_t state, state_nx;

  logic [2:0]            op_q, op_nx;
  logic [1:0]            off_q, off_nx;
  logic [15:0]           wd_q, wd_nx;
  logic                  fault_pend, fault_pend_nx;
  logic [ADDR_WIDTH-1:0] addra_nx;
  logic [DATA_WIDTH-1:0] dina_nx, rdata_nx;
  logic                  wea_nx, ena_nx, rvalid_nx, wdone_nx;

  logic       accept, bad;
  logic [1:0] size, off;
  logic       is_load, is_sw, is_sub;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [DATA_WIDTH-1:0] load_val, merged;
  logic unused;

  assign unused = ^{i_addr[31:ADDR_WIDTH+2]};

  assign o_req_ready = rsta_n && (state == IDLE);
  assign accept = i_req_valid && o_req_ready;
  assign size = i_op[1:0];
  assign off = i_addr[1:0];
  assign bad = (size == 2'b10)
             || (i_op[3] && i_op[2])
             || (size == 2'b01 && off[0])
             || (size == 2'b11 && off != 2'b00);
  assign is_load = !i_op[3];
  assign is_sw = i_op[3] && size == 2'b11;
  assign is_sub = i_op[3] && size != 2'b11;

  assign lane_b = i_douta[{off_q, 3'b000} +: 8];
  assign lane_h = off_q[1] ? i_douta[31:16] : i_douta[15:0];

  always_comb begin
    load_val = i_douta;
    unique case (1'b1)
      (op_q[1:0] == 2'b00):
        load_val = {{24{~op_q[2] & lane_b[7]}}, lane_b};
      (op_q[1:0] == 2'b01):
        load_val = {{16{~op_q[2] & lane_h[15]}}, lane_h};
      default: load_val = i_douta;
    endcase
  end

  always_comb begin
    merged = i_douta;
    if (op_q[1:0] == 2'b00)
      merged[{off_q, 3'b000} +: 8] = wd_q[7:0];
    else
      merged[{off_q[1], 4'b0000} +: 16] = wd_q;
  end

  always_comb begin
    state_nx = state;
    op_nx = op_q;
    off_nx = off_q;
    wd_nx = wd_q;
    addra_nx = o_addra;
    dina_nx = o_dina;
    rdata_nx = o_rdata;
    wea_nx = 1'b0;
    ena_nx = 1'b0;
    rvalid_nx = 1'b0;
    wdone_nx = 1'b0;
    fault_pend_nx = 1'b0;
    case (state)
      IDLE: begin
        if (accept && bad) begin
          fault_pend_nx = 1'b1;
        end else if (accept) begin
          addra_nx = i_addr[ADDR_WIDTH+1:2];
          op_nx = i_op[2:0];
          off_nx = off;
          wd_nx = i_wdata[15:0];
          unique case (1'b1)
            is_load: begin
              state_nx = LD;
              ena_nx = 1'b1;
            end
            is_sw: begin
              state_nx = ST;
              dina_nx = i_wdata;
              wea_nx = 1'b1;
            end
            is_sub: begin
              state_nx = RMW_RD;
              ena_nx = 1'b1;
            end
            default: state_nx = IDLE;
          endcase
        end
      end
      LD: begin
        rdata_nx = load_val;
        rvalid_nx = 1'b1;
        state_nx = IDLE;
      end
      ST: begin
        wdone_nx = 1'b1;
        state_nx = IDLE;
      end
      RMW_RD: begin
        dina_nx = merged;
        wea_nx = 1'b1;
        state_nx = RMW_WR;
      end
      RMW_WR: begin
        wdone_nx = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state <= IDLE;
      op_q <= '0;
      off_q <= '0;
      wd_q <= '0;
      fault_pend <= 1'b0;
      o_fault <= 1'b0;
      o_addra <= '0;
      o_dina <= '0;
      o_rdata <= '0;
      o_wea <= 1'b0;
      o_ena <= 1'b0;
      o_rvalid <= 1'b0;
      o_wdone <= 1'b0;
    end else begin
      state <= state_nx;
      op_q <= op_nx;
      off_q <= off_nx;
      wd_q <= wd_nx;
      fault_pend <= fault_pend_nx;
      o_fault <= fault_pend;
      o_addra <= addra_nx;
      o_dina <= dina_nx;
      o_rdata <= rdata_nx;
      o_wea <= wea_nx;
      o_ena <= ena_nx;
      o_rvalid <= rvalid_nx;
      o_wdone <= wdone_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: negedge RAM model, reference memory,
// response and RAM-write scoreboards.
module tb_mem_access_unit;
  localparam int AW = 10;
  localparam int K_RD = 0;
  localparam int K_WD = 1;
  localparam int K_FT = 2;

  logic clka = 1'b0;
  logic rsta_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] op = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, dina, douta;
  logic rvalid, wdone, fault, wea, ena;
  logic [AW-1:0] addra;

  always #5 clka = ~clka;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clka(clka), .rsta_n(rsta_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_op(op), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_rvalid(rvalid),
    .o_wdone(wdone), .o_fault(fault),
    .o_addra(addra), .o_dina(dina),
    .o_wea(wea), .o_ena(ena), .i_douta(douta)
  );

  logic [31:0] ram [1024];
  initial for (int i = 0; i < 1024; i++) ram[i] <= '0;
  always @(negedge clka) begin
    if (wea) ram[addra] <= dina;
    if (ena) douta <= ram[addra];
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  typedef struct {
    int kind;
    logic [31:0] data;
    int cyc;
  } resp_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0] d;
    int cyc;
  } wr_t;

  resp_t rq[$];
  wr_t wq[$];
  logic [31:0] ref_mem [1024];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: no matching expectation (cycle %0d)", name, cyc);
  endtask

  // Reference: plain byte-lane arithmetic on a word array
  function automatic void predict(input logic [3:0] o, input logic [31:0] a,
                                  input logic [31:0] d, input int n);
    int idx;
    int sh;
    logic [31:0] w, v, m;
    logic [1:0] sz;
    resp_t r;
    wr_t x;
    idx = int'(a[AW+1:2]);
    sh = int'(a[1:0]) * 8;
    w = ref_mem[idx];
    sz = o[1:0];
    if (sz == 2'b10 || (o[3] && o[2]) || (sz == 2'b01 && a[0]) ||
        (sz == 2'b11 && a[1:0] != 2'b00)) begin
      r.kind = K_FT; r.data = '0; r.cyc = n + 1;
      rq.push_back(r);
      return;
    end
    if (!o[3]) begin
      if (sz == 2'b00) begin
        v = (w >> sh) & 32'hFF;
        if (!o[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
        v = (w >> sh) & 32'hFFFF;
        if (!o[2] && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      r.kind = K_RD; r.data = v; r.cyc = n + 1;
      rq.push_back(r);
    end else begin
      if (sz == 2'b11) begin
        v = d;
        x.cyc = n;
        r.cyc = n + 1;
      end else begin
        m = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        v = (w & ~(m << sh)) | ((d & m) << sh);
        x.cyc = n + 1;
        r.cyc = n + 2;
      end
      ref_mem[idx] = v;
      x.a = a[AW+1:2]; x.d = v;
      wq.push_back(x);
      r.kind = K_WD; r.data = '0;
      rq.push_back(r);
    end
  endfunction

  // Called and returns at #1 after a posedge; n is the accept cycle
  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] d, input bit track,
                       output int n);
    int waited;
    waited = 0;
    op = o; addr = a; wdata = d; req_valid = 1'b1;
    while (!req_ready && waited < 20) begin
      @(posedge clka); #1;
      waited++;
    end
    if (!req_ready) begin
      miss("accept_timeout");
      req_valid = 1'b0;
      n = -1;
      return;
    end
    @(posedge clka); #1;
    n = cyc;
    req_valid = 1'b0;
    if (track) predict(o, a, d, n);
  endtask

  initial forever begin
    resp_t e;
    int k;
    @(posedge clka); #1;
    if (rsta_n && (rvalid || wdone || fault)) begin
      k = rvalid ? K_RD : (wdone ? K_WD : K_FT);
      check("single_pulse", $countones({rvalid, wdone, fault}), 1);
      if (rq.size() == 0) begin
        miss("unexpected_resp");
      end else begin
        e = rq.pop_front();
        check("resp_kind", k, e.kind);
        check("resp_cycle", cyc, e.cyc);
        if (k == K_RD) check("rdata", rdata, e.data);
      end
    end
  end

  initial forever begin
    wr_t w;
    @(negedge clka);
    if (wea || ena) check("wea_ena_excl", {31'b0, wea && ena}, 0);
    if (wea) begin
      if (wq.size() == 0) begin
        miss("unexpected_write");
      end else begin
        w = wq.pop_front();
        check("wr_addr", {22'b0, addra}, {22'b0, w.a});
        check("wr_data", dina, w.d);
        check("wr_cycle", cyc, w.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  function automatic logic [31:0] outs_or();
    return rdata | dina | {22'b0, addra} |
           {26'b0, rvalid, wdone, fault, wea, ena, req_ready};
  endfunction

  initial begin
    int n, n1, n2;
    logic [31:0] ra;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    #12;
    check("reset_outs", outs_or(), 0);
    @(negedge clka); rsta_n = 1'b1;
    @(posedge clka); #1;
    check("ready_after_reset", {31'b0, req_ready}, 1);

    issue(4'b1011, 32'h14, 32'h80FF7F01, 1, n);
    issue(4'b1011, 32'h0C, 32'h11223344, 1, n);
    issue(4'b0000, 32'h15, 0, 1, n);
    issue(4'b0000, 32'h17, 0, 1, n);
    issue(4'b0100, 32'h17, 0, 1, n);
    issue(4'b0001, 32'h16, 0, 1, n);
    issue(4'b0101, 32'h16, 0, 1, n);
    issue(4'b0001, 32'h14, 0, 1, n);

    issue(4'b1000, 32'h0E, 32'hAA, 1, n);
    check("sb_ready_n", {31'b0, req_ready}, 0);
    @(posedge clka); #1;
    check("sb_ready_n1", {31'b0, req_ready}, 0);
    @(posedge clka); #1;
    check("sb_ready_n2", {31'b0, req_ready}, 1);
    issue(4'b0011, 32'h0C, 0, 1, n);

    issue(4'b1011, 32'h40, 32'hDEADBEEF, 1, n1);
    issue(4'b0011, 32'h40, 0, 1, n2);
    check("sw_lw_b2b", n2, n1 + 2);
    issue(4'b0011, 32'h1040, 0, 1, n);

    issue(4'b0001, 32'h01, 0, 1, n1);
    issue(4'b0011, 32'h02, 0, 1, n2);
    check("fault_b2b_a", n2, n1 + 1);
    issue(4'b1010, 32'h00, 0, 1, n1);
    check("fault_b2b_b", n1, n2 + 1);
    issue(4'b1100, 32'h00, 0, 1, n2);
    check("fault_b2b_c", n2, n1 + 1);

    issue(4'b1000, 32'h0C, 32'h55, 0, n);
    #1 rsta_n = 1'b0;
    #1 check("reset_mid_rmw", outs_or(), 0);
    @(negedge clka);
    @(negedge clka); rsta_n = 1'b1;
    @(posedge clka); #1;
    check("ready_after_rmw_rst", {31'b0, req_ready}, 1);
    issue(4'b0011, 32'h0C, 0, 1, n);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clka); #1;
      end
      ra = ($urandom & 32'hFFFFF000) |
           (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
      issue(4'($urandom_range(0, 15)), ra, $urandom, 1, n);
    end

    repeat (6) @(posedge clka);
    #1;
    check("resp_queue_empty", rq.size(), 0);
    check("write_queue_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
